lfsr_stream_checker: RTL and testbench
======================================

# lfsr_stream_checker

Downstream consumer of the 8-bit many-to-one LFSR: samples the generator's `out` bus every qualified cycle, locks onto the sequence, predicts each next value, and flags mismatches. It reports an error pulse, a saturating error count, a lock indicator and the measured sequence period. It is the self-check stage placed after the pseudo-random source in the lab datapath and on the board.

## Interface
- `TAP_MASK`, default 8'b1000_1110: feedback bit = XOR of `data_in` bits selected by mask (bits 7,3,2,1); next = {cur[6:0], fb}.
- `SYNC_LEN`, default 4: consecutive correct predictions required to enter LOCKED.
- `LOSS_LEN`, default 3: consecutive mismatches in LOCKED that drop lock.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `data_in` holds a new LFSR sample this cycle.
- `data_in`  in  8  LFSR output sample.
- `locked`  out  1  high while in LOCKED.
- `err_pulse`  out  1  one-cycle pulse per mismatch while LOCKED.
- `err_cnt`  out  8  mismatches since reset, saturates at 255.
- `zero_seen`  out  1  sticky: an all-zero sample was received.
- `period`  out  8  last measured period in samples.
- `period_valid`  out  1  one-cycle pulse when `period` updates.

## Operation
- States: IDLE, HUNT, LOCKED.
- Reset: state IDLE; all outputs 0; internal ref, run counters, anchor, period counter 0.
- Cycles with `in_valid`=0 change nothing (all outputs except pulses hold; pulses low).
- IDLE: first valid nonzero sample -> ref <= next(sample), good_run <= 0, go HUNT. Zero sample: stay IDLE, set `zero_seen`.
- HUNT: valid sample compared to ref. Match: good_run++, ref <= next(sample); when good_run reaches SYNC_LEN, go LOCKED, anchor <= sample, period counter <= 1. Mismatch: good_run <= 0, ref <= next(sample) (reseed). Zero sample: set `zero_seen`, go IDLE. No `err_pulse`/`err_cnt` activity in HUNT.
- LOCKED (flywheel): ref <= next(ref) on every valid sample regardless of match, so a single corrupted sample costs exactly one error. Match: miss_run <= 0. Mismatch: `err_pulse`, `err_cnt`++ (saturating), miss_run++; on reaching LOSS_LEN go HUNT with good_run <= 0, ref <= next(sample), `locked` drops.
- Period: in LOCKED, counter increments per valid sample; when the predicted ref equals anchor on a matching sample, `period` <= counter, `period_valid` pulse, counter <= 1. Counter saturates at 255 without wrapping. Correct generator yields 255.
- Zero sample in LOCKED is an ordinary mismatch (plus `zero_seen`).
- Simultaneous lock-loss and saturation: count holds 255, transition still occurs.

## Timing
- All outputs registered; response appears the cycle after the `in_valid` sample edge.
- `locked` rises one cycle after the SYNC_LEN-th matching sample; falls one cycle after the LOSS_LEN-th consecutive mismatch.
- `err_pulse`, `period_valid`: exactly one cycle wide per event; back-to-back valid samples can produce back-to-back pulses.
- `rst` mid-operation: immediate asynchronous clear to reset values, including sticky `zero_seen` and `err_cnt`.
- Throughput: one sample per cycle, no backpressure.

## Structure
- Package `lfsr_pkg`: TAP_MASK default, reference seed 8'hBD, state encoding constants (IDLE/HUNT/LOCKED), width constant 8.
- Sub-module `lfsr_step`: combinational next-value function (cur, mask -> next), instanced twice (sample path, flywheel path) and reusable by the generator.

## Test plan
- Reset then drive generator from seed 8'hBD (next 8'h7B), 1 sample/cycle -> `locked`=1 one cycle after 5th valid sample (1 seed + 4 matches), `err_cnt`=0.
- Locked, run 600 samples -> `period_valid` pulses with `period`=255, repeating every 255 valid samples.
- Locked, flip bit 0 of one sample -> exactly one `err_pulse`, `err_cnt`=1, `locked` stays 1, next sample matches.
- Locked, corrupt 3 consecutive samples -> `err_cnt`+3, `locked`=0; clean stream resumes -> relock after 4 further matches.
- Drive 8'h00 in IDLE and in HUNT -> `zero_seen`=1, state IDLE, `locked`=0; toggle `in_valid` low between samples -> no state/output change on idle cycles.
- Force 300 mismatches while locked/relocking, then assert `rst` mid-stream -> `err_cnt` held at 255 before reset, all outputs 0 same cycle as `rst` asserts.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants and types for the LFSR stream checker and its generator.
// Holds the default tap mask, reference seed and checker state encoding.
package lfsr_pkg;

  localparam int          LFSR_W           = 8;
  localparam logic [7:0]  TAP_MASK_DEFAULT = 8'b1000_1110;
  localparam logic [7:0]  REF_SEED         = 8'hBD;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational many-to-one LFSR step: shift left, feedback = XOR of masked bits.
// Shared by the checker (sample and flywheel paths) and the generator.
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  input  logic [LFSR_W-1:0] mask,
  output logic [LFSR_W-1:0] next_val
);

  always_comb begin
    next_val = {cur[LFSR_W-2:0], ^(cur & mask)};
  end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Locks onto an 8-bit LFSR stream, predicts each sample, counts mismatches
// and measures the sequence period while locked.
module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter logic [7:0] TAP_MASK = TAP_MASK_DEFAULT,
  parameter int         SYNC_LEN = 4,
  parameter int         LOSS_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] data_in,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_cnt,
  output logic       zero_seen,
  output logic [7:0] period,
  output logic       period_valid
);

  localparam logic [7:0] SYNC_TGT = 8'(SYNC_LEN);
  localparam logic [7:0] LOSS_TGT = 8'(LOSS_LEN);

  chk_state_e state_q, state_d;
  logic [7:0] ref_q, ref_d;
  logic [7:0] good_run_q, good_run_d;
  logic [7:0] miss_run_q, miss_run_d;
  logic [7:0] anchor_q, anchor_d;
  logic [7:0] per_cnt_q, per_cnt_d;
  logic       locked_q, locked_d;
  logic       err_pulse_q, err_pulse_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       zero_seen_q, zero_seen_d;
  logic [7:0] period_q, period_d;
  logic       period_valid_q, period_valid_d;

  logic [7:0] sample_next;
  logic [7:0] flywheel_next;
  logic       sample_zero;
  logic       sample_match;

  lfsr_step u_step_sample (
    .cur      (data_in),
    .mask     (TAP_MASK),
    .next_val (sample_next)
  );

  lfsr_step u_step_flywheel (
    .cur      (ref_q),
    .mask     (TAP_MASK),
    .next_val (flywheel_next)
  );

  assign sample_zero  = (data_in == 8'h00);
  assign sample_match = (data_in == ref_q);

  always_comb begin
    state_d        = state_q;
    ref_d          = ref_q;
    good_run_d     = good_run_q;
    miss_run_d     = miss_run_q;
    anchor_d       = anchor_q;
    per_cnt_d      = per_cnt_q;
    err_cnt_d      = err_cnt_q;
    zero_seen_d    = zero_seen_q;
    period_d       = period_q;
    err_pulse_d    = 1'b0;
    period_valid_d = 1'b0;

    if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (sample_zero) begin
            zero_seen_d = 1'b1;
          end else begin
            ref_d      = sample_next;
            good_run_d = 8'd0;
            state_d    = ST_HUNT;
          end
        end

        ST_HUNT: begin
          if (sample_zero) begin
            zero_seen_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            ref_d = sample_next;
            if (sample_match) begin
              good_run_d = good_run_q + 8'd1;
              if (good_run_q + 8'd1 == SYNC_TGT) begin
                state_d    = ST_LOCKED;
                anchor_d   = data_in;
                per_cnt_d  = 8'd1;
                miss_run_d = 8'd0;
              end
            end else begin
              good_run_d = 8'd0;
            end
          end
        end

        ST_LOCKED: begin
          // Flywheel: prediction advances from ref, so one bad sample costs one error.
          if (sample_zero) begin
            zero_seen_d = 1'b1;
          end
          ref_d     = flywheel_next;
          per_cnt_d = sat_inc8(per_cnt_q);
          if (sample_match) begin
            miss_run_d = 8'd0;
            if (ref_q == anchor_q) begin
              period_d       = per_cnt_q;
              period_valid_d = 1'b1;
              per_cnt_d      = 8'd1;
            end
          end else begin
            err_pulse_d = 1'b1;
            err_cnt_d   = sat_inc8(err_cnt_q);
            miss_run_d  = miss_run_q + 8'd1;
            if (miss_run_q + 8'd1 == LOSS_TGT) begin
              state_d    = ST_HUNT;
              good_run_d = 8'd0;
              ref_d      = sample_next;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ref_q          <= 8'd0;
      good_run_q     <= 8'd0;
      miss_run_q     <= 8'd0;
      anchor_q       <= 8'd0;
      per_cnt_q      <= 8'd0;
      locked_q       <= 1'b0;
      err_pulse_q    <= 1'b0;
      err_cnt_q      <= 8'd0;
      zero_seen_q    <= 1'b0;
      period_q       <= 8'd0;
      period_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ref_q          <= ref_d;
      good_run_q     <= good_run_d;
      miss_run_q     <= miss_run_d;
      anchor_q       <= anchor_d;
      per_cnt_q      <= per_cnt_d;
      locked_q       <= locked_d;
      err_pulse_q    <= err_pulse_d;
      err_cnt_q      <= err_cnt_d;
      zero_seen_q    <= zero_seen_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign locked       = locked_q;
  assign err_pulse    = err_pulse_q;
  assign err_cnt      = err_cnt_q;
  assign zero_seen    = zero_seen_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared one cycle later.
module tb_lfsr_stream_checker;
  import lfsr_pkg::*;

  localparam int SYNC_LEN = 4;
  localparam int LOSS_LEN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] data_in;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic       zero_seen;
  logic [7:0] period;
  logic       period_valid;

  always #5 clk = ~clk;

  lfsr_stream_checker #(
    .TAP_MASK (8'b1000_1110),
    .SYNC_LEN (SYNC_LEN),
    .LOSS_LEN (LOSS_LEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_cnt      (err_cnt),
    .zero_seen    (zero_seen),
    .period       (period),
    .period_valid (period_valid)
  );

  typedef struct packed {
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic       zero_seen;
    logic [7:0] period;
    logic       period_valid;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state: 0 idle, 1 hunting, 2 locked.
  int         m_state;
  logic [7:0] m_ref, m_anchor, m_cnt;
  int         m_good, m_miss;
  exp_t       m_out;
  logic [7:0] g;
  int         pv_count;

  function automatic logic [7:0] tb_next(input logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[3] ^ v[2] ^ v[1];
    return {v[6:0], fb};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_ref    = 8'd0;
    m_anchor = 8'd0;
    m_cnt    = 8'd0;
    m_good   = 0;
    m_miss   = 0;
    m_out    = '0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    logic [7:0] pred;
    m_out.err_pulse    = 1'b0;
    m_out.period_valid = 1'b0;
    if (v) begin
      if (m_state == 0) begin
        if (d == 8'h00) m_out.zero_seen = 1'b1;
        else begin
          m_ref   = tb_next(d);
          m_good  = 0;
          m_state = 1;
        end
      end else if (m_state == 1) begin
        if (d == 8'h00) begin
          m_out.zero_seen = 1'b1;
          m_state = 0;
        end else if (d == m_ref) begin
          m_good++;
          m_ref = tb_next(d);
          if (m_good == SYNC_LEN) begin
            m_state  = 2;
            m_anchor = d;
            m_cnt    = 8'd1;
            m_miss   = 0;
          end
        end else begin
          m_good = 0;
          m_ref  = tb_next(d);
        end
      end else begin
        if (d == 8'h00) m_out.zero_seen = 1'b1;
        pred  = m_ref;
        m_ref = tb_next(m_ref);
        if (d == pred) begin
          m_miss = 0;
          if (pred == m_anchor) begin
            m_out.period       = m_cnt;
            m_out.period_valid = 1'b1;
            m_cnt              = 8'd1;
          end else if (m_cnt != 8'hFF) begin
            m_cnt = m_cnt + 8'd1;
          end
        end else begin
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
          m_out.err_pulse = 1'b1;
          if (m_out.err_cnt != 8'hFF) m_out.err_cnt = m_out.err_cnt + 8'd1;
          m_miss++;
          if (m_miss == LOSS_LEN) begin
            m_state = 1;
            m_good  = 0;
            m_ref   = tb_next(d);
          end
        end
      end
    end
    m_out.locked = (m_state == 2);
    sb_q.push_back(m_out);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check("locked", locked, e.locked);
      check("err_pulse", err_pulse, e.err_pulse);
      check("err_cnt", err_cnt, e.err_cnt);
      check("zero_seen", zero_seen, e.zero_seen);
      check("period", period, e.period);
      check("period_valid", period_valid, e.period_valid);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    in_valid = v;
    data_in  = d;
    model_step(v, d);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic send_gen();
    drive(1'b1, g);
    g = tb_next(g);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, locked, 8'd0);
    check({tag, "_err_pulse"}, err_pulse, 8'd0);
    check({tag, "_err_cnt"}, err_cnt, 8'd0);
    check({tag, "_zero_seen"}, zero_seen, 8'd0);
    check({tag, "_period"}, period, 8'd0);
    check({tag, "_period_valid"}, period_valid, 8'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    data_in  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Acquire lock from the reference seed: 1 seed sample + 4 matches.
    g = REF_SEED;
    check("seed_next", tb_next(g), 8'h7B);
    for (int i = 0; i < 4; i++) send_gen();
    check("not_locked_after_4", locked, 8'd0);
    send_gen();
    check("locked_after_5", locked, 8'd1);
    check("err_cnt_clean", err_cnt, 8'd0);

    // Free-run: period pulses every 255 samples.
    pv_count = 0;
    for (int i = 0; i < 600; i++) begin
      send_gen();
      if (period_valid) begin
        pv_count++;
        check("period_255", period, 8'd255);
      end
    end
    check("pv_pulses", 8'(pv_count), 8'd2);

    // Single bit flip costs exactly one error.
    drive(1'b1, g ^ 8'h01);
    g = tb_next(g);
    check("flip_err_pulse", err_pulse, 8'd1);
    check("flip_err_cnt", err_cnt, 8'd1);
    check("flip_locked", locked, 8'd1);
    send_gen();
    check("flip_recover_pulse", err_pulse, 8'd0);

    // Three consecutive corruptions drop lock; clean stream relocks.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ~g);
      g = tb_next(g);
    end
    check("loss_locked", locked, 8'd0);
    check("loss_err_cnt", err_cnt, 8'd4);
    for (int i = 0; i < 4; i++) send_gen();
    check("relock_pending", locked, 8'd0);
    send_gen();
    check("relocked", locked, 8'd1);

    // Idle cycles interleaved with samples change nothing.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'hA5);
      send_gen();
    end

    // Zero samples in IDLE and HUNT.
    rst = 1'b1;
    model_reset();
    #2;
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 8'h00);
    check("zero_idle", zero_seen, 8'd1);
    send_gen();
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    send_gen();
    drive(1'b1, 8'h00);
    check("zero_hunt_locked", locked, 8'd0);
    for (int i = 0; i < 5; i++) send_gen();
    check("zero_relock", locked, 8'd1);

    // Saturate the error counter with repeated lock loss.
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 3; i++) begin
        drive(1'b1, g ^ 8'h01);
        g = tb_next(g);
      end
      for (int i = 0; i < 5; i++) send_gen();
    end
    check("sat_err_cnt", err_cnt, 8'd255);
    check("sat_locked", locked, 8'd1);

    // Asynchronous reset mid-stream clears everything before the next edge.
    in_valid = 1'b1;
    data_in  = g;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("rst_async");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
